neighbor_table_reader: RTL and testbench
========================================

NEIGHBOR_TABLE_READER -- requirements
Module: neighbor_table_reader

Interface
REQ-001 Parameters SHALL be, one per line:
  WORD_WIDTH  16  width of every neighbor-table field
  MAX_NEIGHBORS  64  table depth in entries
  ADDR_WIDTH  $clog2(MAX_NEIGHBORS)  read-address width
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock, rising edge
  nrst  in  1  asynchronous active-low reset
  start  in  1  scan request, sampled only in IDLE
  neighborCount  in  WORD_WIDTH  number of valid table entries, sampled with start
  minEnergy  in  WORD_WIDTH  energy qualification threshold, sampled with start
  rd_en  out  1  table read strobe
  rd_addr  out  ADDR_WIDTH  table read address
  rdNodeID  in  WORD_WIDTH  entry node ID, valid the cycle after rd_en
  rdNodeHops  in  WORD_WIDTH  entry hop count, valid the cycle after rd_en
  rdNodeQValue  in  WORD_WIDTH  entry Q-value, valid the cycle after rd_en
  rdNodeEnergy  in  WORD_WIDTH  entry residual energy, valid the cycle after rd_en
  busy  out  1  scan in progress
  done  out  1  one-cycle completion pulse
  found  out  1  at least one entry qualified
  bestID  out  WORD_WIDTH  selected next-hop node ID
  bestHops  out  WORD_WIDTH  selected entry hop count
  bestQValue  out  WORD_WIDTH  selected entry Q-value
  bestEnergy  out  WORD_WIDTH  selected entry energy

Function
REQ-003 FSM states SHALL be IDLE, SCAN, DRAIN, DONE.
- IDLE->SCAN: start=1, N>0.
- IDLE->DONE: start=1, N=0.
- SCAN->DRAIN: after the read for address N-1 is issued.
- DRAIN->DONE: after one cycle.
- DONE->IDLE: always.
REQ-004 N SHALL be min(neighborCount, MAX_NEIGHBORS), latched on start acceptance.
REQ-005 In SCAN, rd_en SHALL be 1 every cycle, with rd_addr = 0, 1, ..., N-1 consecutively; outside SCAN, rd_en SHALL be 0 and rd_addr SHALL hold 0.
REQ-006 Each returned entry SHALL be evaluated in the cycle after its rd_en. Candidate registers SHALL update at the end of that cycle.
REQ-007 An entry SHALL qualify iff rdNodeEnergy >= latched minEnergy (unsigned).
REQ-008 A qualified entry SHALL replace the candidate when:
- no candidate exists yet; or
- its Q > candidate Q; or
- its Q = candidate Q and its hops < candidate hops.
All compares SHALL be unsigned. On a full tie, the earlier address SHALL be kept.
REQ-009 The candidate-valid flag SHALL clear on start acceptance.
REQ-010 Latency: with start accepted in cycle 0:
- rd_en is high in cycles 1..N;
- the last data arrives in cycle N+1;
- done is high in cycle N+2.
For N=0, done SHALL be high in cycle 1 and no read SHALL be issued.
REQ-011 done SHALL be high only in the DONE state, for exactly one cycle.
REQ-012 found and best* SHALL load from the candidate registers in the cycle done is high, and SHALL hold until the next done.
REQ-013 If found=0 at done, bestID, bestHops, bestQValue and bestEnergy SHALL be 0.
REQ-014 busy SHALL be 1 in SCAN, DRAIN and DONE, and 0 in IDLE.
REQ-015 start SHALL be ignored while busy=1. Table data inputs SHALL be ignored except in evaluation cycles.
REQ-016 neighborCount and minEnergy changes after acceptance SHALL have no effect on the scan in progress.

Reset
REQ-017 nrst=0 SHALL immediately force:
- state IDLE;
- rd_en, busy, done and found to 0;
- rd_addr and all best* outputs to 0;
- candidate registers cleared.
REQ-018 Reset asserted mid-scan SHALL abort the scan without a done pulse. After reset release, the next start SHALL scan from address 0.

Verification
REQ-019 The bench SHALL cover:
- N=3, minEnergy=10. Entries (ID,hops,Q,E) = (5,2,40,50), (7,1,60,20), (9,3,60,30) -> done in cycle 5, found=1, bestID=7, bestQValue=60, bestHops=1.
- N=2, minEnergy=100, both entries E=50 -> found=0, all best*=0, done in cycle 4.
- neighborCount=0 -> done in cycle 1, rd_en never asserted, found=0.
- neighborCount=200 -> exactly 64 reads, addresses 0..63, done in cycle 66.
- Second start pulse during SCAN -> ignored, read sequence unchanged, single done.
- nrst low in cycle 3 of an N=8 scan -> outputs 0 at once, no done; the following start rescans from address 0.

Source files
------------

// File: rtl/neighbor_table_reader.sv
// Scans a neighbor table one entry per cycle and returns the qualified entry with the
// highest Q-value, with fewest hops breaking ties and the earlier address winning full ties.
module neighbor_table_reader #(
    parameter int WORD_WIDTH    = 16,
    parameter int MAX_NEIGHBORS = 64,
    parameter int ADDR_WIDTH    = $clog2(MAX_NEIGHBORS)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] neighborCount,
    input  logic [WORD_WIDTH-1:0] minEnergy,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [WORD_WIDTH-1:0] rdNodeID,
    input  logic [WORD_WIDTH-1:0] rdNodeHops,
    input  logic [WORD_WIDTH-1:0] rdNodeQValue,
    input  logic [WORD_WIDTH-1:0] rdNodeEnergy,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [WORD_WIDTH-1:0] bestID,
    output logic [WORD_WIDTH-1:0] bestHops,
    output logic [WORD_WIDTH-1:0] bestQValue,
    output logic [WORD_WIDTH-1:0] bestEnergy
);

    // Request/response protocol: start is a request taken only while busy=0 (IDLE);
    // once taken, busy stays high until the single-cycle done pulse, and found/best*
    // are valid in that done cycle and hold their values until the next done.
    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                state;
    state_t                state_nxt;

    logic [CNT_W-1:0]      n_q;
    logic [CNT_W-1:0]      n_sat;
    logic [WORD_WIDTH-1:0] min_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  eval_q;
    logic                  start_acc;
    logic                  last_addr;
    logic                  qualify;
    logic                  better;

    logic                  cand_valid;
    logic [WORD_WIDTH-1:0] cand_id;
    logic [WORD_WIDTH-1:0] cand_hops;
    logic [WORD_WIDTH-1:0] cand_q;
    logic [WORD_WIDTH-1:0] cand_e;

    logic                  held_found;
    logic [WORD_WIDTH-1:0] held_id;
    logic [WORD_WIDTH-1:0] held_hops;
    logic [WORD_WIDTH-1:0] held_q;
    logic [WORD_WIDTH-1:0] held_e;

    assign start_acc = (state == IDLE) && start;
    assign last_addr = ({1'b0, addr_q} == (n_q - CNT_W'(1)));
    assign qualify   = (rdNodeEnergy >= min_q);
    assign better    = !cand_valid
                       || (rdNodeQValue > cand_q)
                       || ((rdNodeQValue == cand_q) && (rdNodeHops < cand_hops));

    always_comb begin
        n_sat = neighborCount[CNT_W-1:0];
        if (neighborCount >= WORD_WIDTH'(MAX_NEIGHBORS)) begin
            n_sat = CNT_W'(MAX_NEIGHBORS);
        end
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (n_sat == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (last_addr) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read address counter, evaluation pipeline and candidate tracking
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            n_q        <= '0;
            min_q      <= '0;
            addr_q     <= '0;
            eval_q     <= 1'b0;
            cand_valid <= 1'b0;
            cand_id    <= '0;
            cand_hops  <= '0;
            cand_q     <= '0;
            cand_e     <= '0;
            held_found <= 1'b0;
            held_id    <= '0;
            held_hops  <= '0;
            held_q     <= '0;
            held_e     <= '0;
        end else begin
            eval_q <= (state == SCAN);

            if (state == SCAN) begin
                addr_q <= last_addr ? '0 : addr_q + ADDR_WIDTH'(1);
            end else begin
                addr_q <= '0;
            end

            // Candidate data is zeroed with the flag so an empty result reads as all zeros.
            if (start_acc) begin
                n_q        <= n_sat;
                min_q      <= minEnergy;
                cand_valid <= 1'b0;
                cand_id    <= '0;
                cand_hops  <= '0;
                cand_q     <= '0;
                cand_e     <= '0;
            end else if (eval_q && qualify && better) begin
                cand_valid <= 1'b1;
                cand_id    <= rdNodeID;
                cand_hops  <= rdNodeHops;
                cand_q     <= rdNodeQValue;
                cand_e     <= rdNodeEnergy;
            end

            if (state == DONE) begin
                held_found <= cand_valid;
                held_id    <= cand_id;
                held_hops  <= cand_hops;
                held_q     <= cand_q;
                held_e     <= cand_e;
            end
        end
    end

    // Outputs: during DONE the result is taken straight from the candidate registers,
    // afterwards from the copy captured at the end of DONE.
    always_comb begin
        rd_en      = (state == SCAN);
        rd_addr    = addr_q;
        busy       = (state != IDLE);
        done       = (state == DONE);
        found      = held_found;
        bestID     = held_id;
        bestHops   = held_hops;
        bestQValue = held_q;
        bestEnergy = held_e;
        if (state == DONE) begin
            found      = cand_valid;
            bestID     = cand_id;
            bestHops   = cand_hops;
            bestQValue = cand_q;
            bestEnergy = cand_e;
        end
    end

endmodule

// File: tb/tb_neighbor_table_reader.sv
// Randomized bench for neighbor_table_reader: a table responder, a reference model of the
// selection rule, and a monitor that checks reads and done results against expected queues.
module tb_neighbor_table_reader;

    localparam int W     = 16;
    localparam int MAXN  = 64;
    localparam int AW    = 6;
    localparam int EXP_W = 32 + 1 + 4 * W;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start;
    logic [W-1:0]  neighborCount;
    logic [W-1:0]  minEnergy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rdNodeID;
    logic [W-1:0]  rdNodeHops;
    logic [W-1:0]  rdNodeQValue;
    logic [W-1:0]  rdNodeEnergy;
    logic          busy;
    logic          done;
    logic          found;
    logic [W-1:0]  bestID;
    logic [W-1:0]  bestHops;
    logic [W-1:0]  bestQValue;
    logic [W-1:0]  bestEnergy;

    logic [W-1:0]  t_id   [MAXN];
    logic [W-1:0]  t_hops [MAXN];
    logic [W-1:0]  t_q    [MAXN];
    logic [W-1:0]  t_e    [MAXN];

    logic [EXP_W-1:0] exp_q[$];
    logic [AW-1:0]    exp_addr_q[$];

    int cyc      = 0;
    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    neighbor_table_reader #(
        .WORD_WIDTH   (W),
        .MAX_NEIGHBORS(MAXN),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .start        (start),
        .neighborCount(neighborCount),
        .minEnergy    (minEnergy),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rdNodeID     (rdNodeID),
        .rdNodeHops   (rdNodeHops),
        .rdNodeQValue (rdNodeQValue),
        .rdNodeEnergy (rdNodeEnergy),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .bestID       (bestID),
        .bestHops     (bestHops),
        .bestQValue   (bestQValue),
        .bestEnergy   (bestEnergy)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: highest Q among qualified entries, then fewest hops, then lowest address.
    function automatic void ref_model(input int n, input logic [W-1:0] mine, output logic f,
                                      output logic [W-1:0] id, output logic [W-1:0] h,
                                      output logic [W-1:0] q, output logic [W-1:0] e);
        int best_q;
        int best_h;
        f = 1'b0; id = '0; h = '0; q = '0; e = '0;
        best_q = -1;
        best_h = 1 << 20;
        for (int i = 0; i < n; i++)
            if (t_e[i] >= mine && int'(t_q[i]) > best_q) best_q = int'(t_q[i]);
        for (int i = 0; i < n; i++)
            if (t_e[i] >= mine && int'(t_q[i]) == best_q && int'(t_hops[i]) < best_h)
                best_h = int'(t_hops[i]);
        for (int i = n - 1; i >= 0; i--)
            if (t_e[i] >= mine && int'(t_q[i]) == best_q && int'(t_hops[i]) == best_h) begin
                f = 1'b1; id = t_id[i]; h = t_hops[i]; q = t_q[i]; e = t_e[i];
            end
    endfunction

    // Table responder: data for a read strobed in one cycle appears in the next cycle;
    // in any other cycle the data lines carry noise that must be ignored.
    initial begin
        logic          s_en;
        logic [AW-1:0] s_addr;
        s_en = 1'b0;
        s_addr = '0;
        rdNodeID = '0; rdNodeHops = '0; rdNodeQValue = '0; rdNodeEnergy = '0;
        forever begin
            @(negedge clk);
            s_en = rd_en;
            s_addr = rd_addr;
            @(posedge clk);
            #1;
            if (s_en) begin
                rdNodeID = t_id[s_addr]; rdNodeHops = t_hops[s_addr];
                rdNodeQValue = t_q[s_addr]; rdNodeEnergy = t_e[s_addr];
            end else begin
                rdNodeID = W'($urandom); rdNodeHops = W'($urandom);
                rdNodeQValue = W'($urandom); rdNodeEnergy = W'($urandom);
            end
        end
    end

    // Monitor: read addresses every cycle, results on every done pulse
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rd_en) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected actual addr=%0d expected no read (cycle %0d)", rd_addr, cyc);
                end else begin
                    check("rd_addr", 64'(rd_addr), 64'(exp_addr_q.pop_front()));
                end
            end else begin
                check("rd_addr_idle", 64'(rd_addr), 64'd0);
            end
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected actual done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e[EXP_W-1 -: 32]));
                    check("found",      64'(found),      64'(e[4*W]));
                    check("bestID",     64'(bestID),     64'(e[4*W-1 -: W]));
                    check("bestHops",   64'(bestHops),   64'(e[3*W-1 -: W]));
                    check("bestQValue", 64'(bestQValue), 64'(e[2*W-1 -: W]));
                    check("bestEnergy", 64'(bestEnergy), 64'(e[W-1:0]));
                    check("reads_left", 64'(exp_addr_q.size()), 64'd0);
                    check("busy_at_done", 64'(busy), 64'd1);
                end
            end
        end
    end

    task automatic fill_random(input int qmax, input int hmax, input int emax);
        for (int i = 0; i < MAXN; i++) begin
            t_id[i]   = W'($urandom_range(0, 65535));
            t_hops[i] = W'($urandom_range(0, hmax));
            t_q[i]    = W'($urandom_range(0, qmax));
            t_e[i]    = W'($urandom_range(0, emax));
        end
    endtask

    task automatic set_entry(input int i, input int id, input int h, input int q, input int e);
        t_id[i] = W'(id); t_hops[i] = W'(h); t_q[i] = W'(q); t_e[i] = W'(e);
    endtask

    // Drives one scan, optionally with a second start pulse while scanning.
    task automatic do_scan(input int nc, input logic [W-1:0] mine, input bit extra_start);
        int           n;
        int           d0;
        logic         f;
        logic [W-1:0] id, h, q, e;
        n = (nc > MAXN) ? MAXN : nc;
        ref_model(n, mine, f, id, h, q, e);
        for (int i = 0; i < n; i++) exp_addr_q.push_back(AW'(i));
        exp_q.push_back({32'(cyc + ((n == 0) ? 1 : n + 2)), f, id, h, q, e});
        check("busy_idle", 64'(busy), 64'd0);
        d0 = done_cnt;
        neighborCount = W'(nc);
        minEnergy = mine;
        start = 1'b1;
        tick();
        start = 1'b0;
        neighborCount = W'($urandom);
        minEnergy = W'($urandom);
        if (extra_start) begin
            tick();
            start = 1'b1;
            neighborCount = W'(5);
            minEnergy = '0;
            tick();
            start = 1'b0;
        end
        for (int k = 0; k < n + 10 && done_cnt == d0; k++) tick();
        repeat (3) tick();
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("hold_found", 64'(found), 64'(f));
        check("hold_bestID", 64'(bestID), 64'(id));
        check("hold_bestHops", 64'(bestHops), 64'(h));
        check("hold_bestQValue", 64'(bestQValue), 64'(q));
        check("hold_bestEnergy", 64'(bestEnergy), 64'(e));
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic reset_mid_scan();
        int d0;
        fill_random(3, 3, 24);
        for (int i = 0; i < 8; i++) exp_addr_q.push_back(AW'(i));
        neighborCount = W'(8);
        minEnergy = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        nrst = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        #1;
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_found", 64'(found), 64'd0);
        check("rst_best", 64'({bestID, bestHops, bestQValue, bestEnergy}), 64'd0);
        d0 = done_cnt;
        repeat (2) tick();
        nrst = 1'b1;
        repeat (14) tick();
        check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        do_scan(8, W'(5), 1'b0);
    endtask

    initial begin
        nrst = 1'b0;
        start = 1'b0;
        neighborCount = '0;
        minEnergy = '0;
        for (int i = 0; i < MAXN; i++) set_entry(i, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_en", 64'(rd_en), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_found", 64'(found), 64'd0);
        check("reset_bestID", 64'(bestID), 64'd0);
        check("reset_rd_addr", 64'(rd_addr), 64'd0);
        nrst = 1'b1;
        tick();

        set_entry(0, 5, 2, 40, 50);
        set_entry(1, 7, 1, 60, 20);
        set_entry(2, 9, 3, 60, 30);
        do_scan(3, W'(10), 1'b0);

        reset_mid_scan();

        set_entry(0, 11, 1, 90, 50);
        set_entry(1, 12, 2, 80, 50);
        do_scan(2, W'(100), 1'b0);

        do_scan(0, W'(0), 1'b0);

        fill_random(7, 7, 30);
        do_scan(200, W'(12), 1'b0);

        fill_random(3, 3, 24);
        do_scan(6, W'(4), 1'b1);

        for (int r = 0; r < 12; r++) begin
            fill_random(3, 3, 24);
            do_scan($urandom_range(0, 70), W'($urandom_range(0, 20)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
